// File: rtl/c17_pkg.sv
// Shared constants for the c17 datapath: operand/result bit positions and core latency.
// Also holds the lowest-set-bit picker used by the round-robin arbiter.
package c17_pkg;

    localparam int OP_W    = 5;
    localparam int RES_W   = 2;
    localparam int C17_LAT = 2;

    localparam int N1_IDX  = 0;
    localparam int N2_IDX  = 1;
    localparam int N3_IDX  = 2;
    localparam int N6_IDX  = 3;
    localparam int N7_IDX  = 4;

    localparam int N22_IDX = 0;
    localparam int N23_IDX = 1;

    // One-hot of the lowest set bit; all-zero in gives all-zero out.
    function automatic logic [7:0] lowest_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/c17_pipe_core.sv
// Registered c17 datapath: operand flops, six NAND2 gates, result flops.
// No reset; the arbiter gates the result with its tag valid.
module c17_pipe_core
    import c17_pkg::*;
(
    input  logic             clk,
    input  logic [OP_W-1:0]  op,
    output logic [RES_W-1:0] res
);

    logic [OP_W-1:0]  in_reg;
    logic [RES_W-1:0] out_reg;
    logic [RES_W-1:0] out_next;
    logic n10, n11, n16, n19;

    always_ff @(posedge clk) begin
        in_reg  <= op;
        out_reg <= out_next;
    end

    always_comb begin
        n10 = ~(in_reg[N1_IDX] & in_reg[N3_IDX]);
        n11 = ~(in_reg[N3_IDX] & in_reg[N6_IDX]);
        n16 = ~(in_reg[N2_IDX] & n11);
        n19 = ~(n11 & in_reg[N7_IDX]);
        out_next          = '0;
        out_next[N22_IDX] = ~(n10 & n16);
        out_next[N23_IDX] = ~(n16 & n19);
    end

    assign res = out_reg;

endmodule

// File: rtl/c17_pipe_arbiter.sv
// Round-robin arbiter sharing one pipelined c17 core among NREQ requesters.
// A {valid,id} tag pipe runs alongside the core so each result returns with its requester ID.
module c17_pipe_arbiter
    import c17_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = C17_LAT
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*OP_W-1:0]   op,
    output logic [NREQ-1:0]        gnt,
    output logic                   res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [RES_W-1:0]       res_data,
    output logic                   busy,
    output logic [15:0]            issued_cnt
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr_reg;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  req_masked;
    logic [NREQ-1:0]  hi_mask;
    logic [7:0]       hi_ext;
    logic [7:0]       all_ext;
    logic [7:0]       pick;
    logic [NREQ-1:0]  gnt_next;
    logic [IDW-1:0]   gnt_id;
    logic             any_gnt;
    logic [OP_W-1:0]  op_slice [NREQ];
    logic [OP_W-1:0]  core_op;
    logic [RES_W-1:0] core_res;
    logic [LAT-1:0]   tag_valid_reg;
    logic [IDW-1:0]   tag_id_reg [LAT];
    logic [15:0]      issued_cnt_reg;

    // Reset is folded into the request mask so no grant escapes during a reset cycle.
    assign req_masked = req & {NREQ{en & ~rst}};

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign hi_mask[gi]  = (IDW'(gi) >= ptr_reg);
            assign op_slice[gi] = op[gi*OP_W +: OP_W];
        end
    endgenerate

    // Prefer requests at or above the pointer; fall back to the lowest overall (wrap-around).
    always_comb begin
        hi_ext  = 8'(req_masked & hi_mask);
        all_ext = 8'(req_masked);
        pick    = (hi_ext != 8'd0) ? lowest_onehot(hi_ext) : lowest_onehot(all_ext);
    end

    assign gnt_next = pick[NREQ-1:0];
    assign any_gnt  = |gnt_next;

    always_comb begin
        gnt_id  = '0;
        core_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_next[i]) begin
                gnt_id  = IDW'(i);
                core_op = core_op | op_slice[i];
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (any_gnt) begin
            ptr_next = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg        <= '0;
            tag_valid_reg  <= '0;
            issued_cnt_reg <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id_reg[i] <= '0;
            end
        end else begin
            ptr_reg          <= ptr_next;
            issued_cnt_reg   <= issued_cnt_reg + 16'(any_gnt);
            tag_valid_reg[0] <= any_gnt;
            tag_id_reg[0]    <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
        end
    end

    c17_pipe_core u_core (
        .clk (clk),
        .op  (core_op),
        .res (core_res)
    );

    assign gnt        = gnt_next;
    assign res_valid  = tag_valid_reg[LAT-1];
    assign res_id     = res_valid ? tag_id_reg[LAT-1] : '0;
    assign res_data   = res_valid ? core_res : '0;
    assign busy       = |tag_valid_reg;
    assign issued_cnt = issued_cnt_reg;

endmodule
